// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg: register offsets, mcause codes and reset constants shared by the
// interrupt controller and its bench.
package irq_controller_pkg;
   localparam logic [4:0] OFF_MSIP        = 5'h00;
   localparam logic [4:0] OFF_MTIMECMP_LO = 5'h04;
   localparam logic [4:0] OFF_MTIMECMP_HI = 5'h08;
   localparam logic [4:0] OFF_MTIME_LO    = 5'h0C;
   localparam logic [4:0] OFF_MTIME_HI    = 5'h10;
   localparam logic [4:0] OFF_EXT_PEND    = 5'h14;
   localparam logic [4:0] OFF_EXT_EN      = 5'h18;
   localparam logic [4:0] OFF_CLAIM       = 5'h1C;
   localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
   localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
   localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: synchronises one asynchronous request line and emits a one-cycle
// pulse on each rising edge of the synchronised value.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end
   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/irq_controller.sv
// irq_controller: machine-mode timer, software and edge-triggered external interrupt
// source with a word-addressed register bus and a registered interrupt/cause output.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int N_EXT       = 8,
   parameter int PRESCALE    = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             bus_sel_i,
   input  logic             bus_we_i,
   input  logic [4:0]       bus_addr_i,
   input  logic [31:0]      bus_wdata_i,
   output logic [31:0]      bus_rdata_o,
   output logic             bus_rvalid_o,
   input  logic [N_EXT-1:0] ext_irq_i,
   output logic             interrupt_o,
   output logic [31:0]      irq_cause_o
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
   logic [PW-1:0]    pre_q, pre_d;
   logic [63:0]      mtime_q, mtime_d, mtimecmp_q, mtimecmp_d, mtime_inc;
   logic             msip_q, msip_d;
   logic [N_EXT-1:0] pend_q, pend_d, en_q, en_d, rise, hit, claim_oh;
   logic [31:0]      rdata_q, rdata_d, rdata_mux, claim_id, cause_q, cause_d;
   logic             rvalid_q, irq_q, irq_d;
   logic             wr, rd, tick, mtip, mei;
   logic [4:0]       addr;
   for (genvar g = 0; g < N_EXT; g++) begin : g_sync
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .d_i    (ext_irq_i[g]),
         .rise_o (rise[g])
      );
   end
   assign addr = bus_addr_i & 5'h1C;
   assign wr   = bus_sel_i & bus_we_i;
   assign rd   = bus_sel_i & ~bus_we_i;
   assign tick = (pre_q == PRE_MAX);
   assign hit  = pend_q & en_q;
   assign mtip = (mtime_q >= mtimecmp_q);
   assign mei  = |hit;
   // Lowest-numbered enabled pending line wins the claim.
   always_comb begin
      claim_id = '0;
      claim_oh = '0;
      for (int i = N_EXT - 1; i >= 0; i--)
         if (hit[i]) begin
            claim_id    = 32'(i + 1);
            claim_oh    = '0;
            claim_oh[i] = 1'b1;
         end
   end
   always_comb begin
      rdata_mux = '0;
      case (addr)
         OFF_MSIP:        rdata_mux = {31'd0, msip_q};
         OFF_MTIMECMP_LO: rdata_mux = mtimecmp_q[31:0];
         OFF_MTIMECMP_HI: rdata_mux = mtimecmp_q[63:32];
         OFF_MTIME_LO:    rdata_mux = mtime_q[31:0];
         OFF_MTIME_HI:    rdata_mux = mtime_q[63:32];
         OFF_EXT_PEND:    rdata_mux = {{(32-N_EXT){1'b0}}, pend_q};
         OFF_EXT_EN:      rdata_mux = {{(32-N_EXT){1'b0}}, en_q};
         OFF_CLAIM:       rdata_mux = claim_id;
         default:         rdata_mux = '0;
      endcase
   end
   // A bus write to one mtime half overrides that half's increment only.
   always_comb begin
      pre_d      = tick ? '0 : pre_q + 1'b1;
      mtime_inc  = mtime_q + 64'(tick);
      mtime_d    = {(wr && addr == OFF_MTIME_HI) ? bus_wdata_i : mtime_inc[63:32],
                    (wr && addr == OFF_MTIME_LO) ? bus_wdata_i : mtime_inc[31:0]};
      mtimecmp_d = {(wr && addr == OFF_MTIMECMP_HI) ? bus_wdata_i : mtimecmp_q[63:32],
                    (wr && addr == OFF_MTIMECMP_LO) ? bus_wdata_i : mtimecmp_q[31:0]};
      msip_d     = (wr && addr == OFF_MSIP) ? bus_wdata_i[0] : msip_q;
      en_d       = (wr && addr == OFF_EXT_EN) ? bus_wdata_i[N_EXT-1:0] : en_q;
      pend_d     = (pend_q & ~((rd && addr == OFF_CLAIM) ? claim_oh : '0)) | rise;
      rdata_d    = rd ? rdata_mux : rdata_q;
      irq_d      = msip_q | mtip | mei;
      cause_d    = mei ? CAUSE_MEI : msip_q ? CAUSE_MSI : mtip ? CAUSE_MTI : '0;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pre_q      <= '0;
         mtime_q    <= '0;
         mtimecmp_q <= MTIMECMP_RST;
         msip_q     <= 1'b0;
         pend_q     <= '0;
         en_q       <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         irq_q      <= 1'b0;
         cause_q    <= '0;
      end else begin
         pre_q      <= pre_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         pend_q     <= pend_d;
         en_q       <= en_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rd;
         irq_q      <= irq_d;
         cause_q    <= cause_d;
      end
   end
   assign bus_rdata_o  = rdata_q;
   assign bus_rvalid_o = rvalid_q;
   assign interrupt_o  = irq_q;
   assign irq_cause_o  = cause_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed register-bus and external-line vectors with hand-computed
// expectations for irq_controller (N_EXT=8, PRESCALE=1, SYNC_STAGES=2).
module tb_irq_controller;
   import irq_controller_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel, we;
   logic [4:0]  addr;
   logic [31:0] wdata, rdata, cause, d;
   logic        rvalid, irq;
   logic [7:0]  ext;
   int          checks = 0;
   int          errors = 0;
   irq_controller #(.N_EXT(8), .PRESCALE(1), .SYNC_STAGES(2)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .bus_sel_i    (sel),
      .bus_we_i     (we),
      .bus_addr_i   (addr),
      .bus_wdata_i  (wdata),
      .bus_rdata_o  (rdata),
      .bus_rvalid_o (rvalid),
      .ext_irq_i    (ext),
      .interrupt_o  (irq),
      .irq_cause_o  (cause)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic bus_wr(input logic [4:0] a, input logic [31:0] v);
      @(negedge clk);
      sel = 1'b1; we = 1'b1; addr = a; wdata = v;
      @(negedge clk);
      sel = 1'b0; we = 1'b0;
      chk("wr_no_rvalid", {31'd0, rvalid}, 32'd0);
   endtask
   task automatic bus_rd(input logic [4:0] a, output logic [31:0] v);
      @(negedge clk);
      sel = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      sel = 1'b0;
      chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
      v = rdata;
   endtask
   task automatic pulse(input int b);
      ext[b] = 1'b1;
      repeat (3) @(negedge clk);
      ext[b] = 1'b0;
      repeat (3) @(negedge clk);
   endtask
   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; ext = '0;
      repeat (3) @(negedge clk);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_cause", cause, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      rst_n = 1'b1;
      bus_rd(OFF_MTIME_LO, d);    chk("mtime_lo_start", d, 32'd1);
      bus_rd(OFF_MTIME_HI, d);    chk("mtime_hi_start", d, 32'd0);
      bus_rd(OFF_MTIMECMP_HI, d); chk("cmp_hi_rst", d, 32'hFFFF_FFFF);
      bus_rd(OFF_MTIMECMP_LO, d); chk("cmp_lo_rst", d, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("rvalid_pulse", {31'd0, rvalid}, 32'd0);
      chk("rdata_hold", rdata, 32'hFFFF_FFFF);
      // timer: mtime forced to 10, compare at 20
      bus_wr(OFF_MTIMECMP_HI, 32'd0);
      bus_wr(OFF_MTIMECMP_LO, 32'd20);
      bus_wr(OFF_MTIME_LO, 32'd10);
      chk("mti_idle", {31'd0, irq}, 32'd0);
      repeat (10) @(negedge clk);
      chk("mti_at_20", {31'd0, irq}, 32'd0);
      @(negedge clk);
      chk("mti_irq", {31'd0, irq}, 32'd1);
      chk("mti_cause", cause, CAUSE_MTI);
      bus_wr(OFF_MTIMECMP_HI, 32'd1);
      chk("mti_lag", {31'd0, irq}, 32'd1);
      @(negedge clk);
      chk("mti_clear", {31'd0, irq}, 32'd0);
      chk("mti_clear_cause", cause, 32'd0);
      bus_wr(OFF_MTIMECMP_HI, 32'd0);
      @(negedge clk);
      chk("mti_again", cause, CAUSE_MTI);
      // software over timer
      bus_wr(OFF_MSIP, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("msi_cause", cause, CAUSE_MSI);
      bus_rd(OFF_MSIP, d); chk("msip_read", d, 32'd1);
      bus_wr(OFF_MSIP, 32'd0);
      @(negedge clk);
      chk("msi_off_cause", cause, CAUSE_MTI);
      bus_wr(OFF_MTIMECMP_HI, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("timer_off", {31'd0, irq}, 32'd0);
      // external lines
      bus_wr(OFF_EXT_EN, 32'h0C);
      bus_rd(5'h1B, d); chk("en_low_bits_ignored", d, 32'h0C);
      pulse(3);
      pulse(2);
      bus_rd(OFF_EXT_PEND, d); chk("pend_0c", d, 32'h0C);
      chk("mei_irq", {31'd0, irq}, 32'd1);
      chk("mei_cause", cause, CAUSE_MEI);
      bus_rd(OFF_CLAIM, d); chk("claim_3", d, 32'd3);
      bus_rd(OFF_CLAIM, d); chk("claim_4", d, 32'd4);
      @(negedge clk);
      chk("mei_clear", {31'd0, irq}, 32'd0);
      bus_rd(OFF_CLAIM, d); chk("claim_none", d, 32'd0);
      pulse(0);
      bus_rd(OFF_EXT_PEND, d); chk("pend_disabled", d, 32'h01);
      chk("disabled_no_irq", {31'd0, irq}, 32'd0);
      bus_rd(OFF_CLAIM, d); chk("claim_disabled", d, 32'd0);
      // claim coincides with a new synchronised rise on line 2
      pulse(2);
      ext[2] = 1'b1;
      @(negedge clk);
      bus_rd(OFF_CLAIM, d); chk("collide_claim", d, 32'd3);
      bus_rd(OFF_EXT_PEND, d); chk("collide_pend", d, 32'h05);
      bus_rd(OFF_CLAIM, d); chk("collide_reclaim", d, 32'd3);
      bus_rd(OFF_EXT_PEND, d); chk("collide_pend_after", d, 32'h01);
      ext[2] = 1'b0;
      // 64-bit wrap
      bus_wr(OFF_MTIME_HI, 32'hFFFF_FFFF);
      bus_wr(OFF_MTIME_LO, 32'hFFFF_FFFE);
      @(negedge clk);
      bus_rd(OFF_MTIME_HI, d); chk("wrap_hi", d, 32'd0);
      bus_rd(OFF_MTIME_LO, d); chk("wrap_lo", d, 32'd2);
      // asynchronous reset while active
      bus_wr(OFF_MSIP, 32'd1);
      @(negedge clk);
      chk("pre_reset_irq", {31'd0, irq}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_irq", {31'd0, irq}, 32'd0);
      chk("async_cause", cause, 32'd0);
      chk("async_rdata", rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus_rd(OFF_MTIME_LO, d);    chk("async_mtime", d, 32'd1);
      bus_rd(OFF_MSIP, d);        chk("async_msip", d, 32'd0);
      bus_rd(OFF_EXT_EN, d);      chk("async_en", d, 32'd0);
      bus_rd(OFF_EXT_PEND, d);    chk("async_pend", d, 32'd0);
      bus_rd(OFF_MTIMECMP_HI, d); chk("async_cmp_hi", d, 32'hFFFF_FFFF);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
